hv_power_sequencer: RTL and testbench

- Controls power-up and power-down order for the tube supplies: FAN -> CATHODE -> G1 -> ANODE -> G2 -> DRIVE AMP.
- Driven by the standby and HV on/off requests. Each supply is checked against its ACT acknowledge, and each stage must wait its delay.
- Sits between the input synchroniser flops and the supply-enable drivers, in the divided-clock domain.
- Any interlock fault or acknowledge failure drops every enable in one cycle and latches which stage failed.

---
 rtl/hv_seq_pkg.sv | 59 +++++
 rtl/hv_power_sequencer_seq_timer.sv | 34 +++
 rtl/hv_power_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_hv_power_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hv_seq_pkg
// Description : Shared types and helpers for the HV tube-supply sequencer.
//               State encoding, stage indices and enable-vector helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hv_seq_pkg;

    // Values are visible on o_state, so they are pinned explicitly.
    typedef enum logic [3:0] {
        ST_OFF         = 4'd0,
        ST_UP_WAIT_ACK = 4'd1,
        ST_UP_DWELL    = 4'd2,
        ST_SB_READY    = 4'd3,
        ST_HV_READY    = 4'd4,
        ST_DOWN_STEP   = 4'd5,
        ST_FAULT       = 4'd6
    } seq_state_t;

    localparam logic [2:0] STG_FAN   = 3'd0;
    localparam logic [2:0] STG_CA    = 3'd1;
    localparam logic [2:0] STG_G1    = 3'd2;
    localparam logic [2:0] STG_AN    = 3'd3;
    localparam logic [2:0] STG_G2    = 3'd4;
    localparam logic [2:0] STG_DRAMP = 3'd5;

    localparam logic [2:0] FAULT_INTERLOCK = 3'd7;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [2:0] lowest_set(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Index of the highest set bit (0 when the vector is empty).
    function automatic logic [2:0] highest_set(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Enable vector with its highest set bit removed.
    function automatic logic [5:0] clear_highest(input logic [5:0] v);
        logic [5:0] r;
        r = v;
        if (|v) r[highest_set(v)] = 1'b0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hv_power_sequencer_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Loadable down-counter. Loading value N makes o_done rise N
//               clocks later; the count holds at zero instead of wrapping.
// Ports       : clk, reset (async, active-high), i_load, i_load_val, o_done
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/hv_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hv_power_sequencer
// Description : Power-up / power-down sequencer for the tube supplies
//               FAN -> CATHODE -> G1 -> ANODE -> G2 -> DRIVE AMP, with ACT
//               acknowledge supervision, interlock shutdown and fault latch.
// Ports       : clk, reset (async, active-high)
//               i_sb_on_req / i_sb_off_req / i_hv_on_req / i_hv_off_req
//               i_interlock_ok, i_fault_clear, i_act[5:0]
//               o_enable[5:0], o_sb_ready, o_hv_ready, o_seq_fault,
//               o_fault_stage[2:0], o_state[3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module hv_power_sequencer
    import hv_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT   = 2000,
    parameter int STEP_DELAY    = 500,
    parameter int CA_HEAT_DELAY = 60000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sb_on_req,
    input  logic       i_sb_off_req,
    input  logic       i_hv_on_req,
    input  logic       i_hv_off_req,
    input  logic       i_interlock_ok,
    input  logic       i_fault_clear,
    input  logic [5:0] i_act,
    output logic [5:0] o_enable,
    output logic       o_sb_ready,
    output logic       o_hv_ready,
    output logic       o_seq_fault,
    output logic [2:0] o_fault_stage,
    output logic [3:0] o_state
);

    localparam int C_MAX_AS    = (ACK_TIMEOUT > STEP_DELAY) ? ACK_TIMEOUT : STEP_DELAY;
    localparam int C_MAX_DELAY = (C_MAX_AS > CA_HEAT_DELAY) ? C_MAX_AS : CA_HEAT_DELAY;
    localparam int C_CNT_W     = $clog2(C_MAX_DELAY + 1);

    // The timer raises done N clocks after loading N, so load (delay - 1)
    // to get the transition exactly 'delay' edges after entry.
    localparam logic [C_CNT_W-1:0] C_ACK_LOAD  = C_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0] C_STEP_LOAD = C_CNT_W'(STEP_DELAY - 1);
    localparam logic [C_CNT_W-1:0] C_HEAT_LOAD = C_CNT_W'(CA_HEAT_DELAY - 1);

    seq_state_t   r_state,   w_state;
    logic [5:0]   r_enable,  w_enable;
    logic [2:0]   r_stage,   w_stage;
    logic         r_floor_hi, w_floor_hi;   // 1: stop at G1 (SB_READY), 0: stop at OFF
    logic         r_sb_ready, w_sb_ready;
    logic         r_hv_ready, w_hv_ready;
    logic         r_seq_fault, w_seq_fault;
    logic [2:0]   r_fault_stage, w_fault_stage;

    logic               w_load;
    logic [C_CNT_W-1:0] w_load_val;
    logic               w_timer_done;

    logic [5:0] w_act_lost;
    logic       w_hv_ramp;
    logic [2:0] w_next_stage;
    logic       w_below_floor;

    seq_timer #(
        .WIDTH (C_CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_timer_done)
    );

    assign w_act_lost   = r_enable & ~i_act;
    assign w_hv_ramp    = ((r_state == ST_UP_WAIT_ACK) || (r_state == ST_UP_DWELL)) &&
                          (r_stage >= STG_G1);
    assign w_next_stage = r_stage + 3'd1;

    always_comb begin
        w_state       = r_state;
        w_enable      = r_enable;
        w_stage       = r_stage;
        w_floor_hi    = r_floor_hi;
        w_seq_fault   = r_seq_fault;
        w_fault_stage = r_fault_stage;
        w_load        = 1'b0;
        w_load_val    = C_STEP_LOAD;
        w_below_floor = 1'b0;

        if ((r_state != ST_OFF) && (r_state != ST_FAULT) && !i_interlock_ok) begin
            w_state       = ST_FAULT;
            w_enable      = '0;
            w_seq_fault   = 1'b1;
            w_fault_stage = FAULT_INTERLOCK;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (i_sb_on_req && i_interlock_ok) begin
                        w_state    = ST_UP_WAIT_ACK;
                        w_stage    = STG_FAN;
                        w_enable   = 6'b000001;
                        w_load     = 1'b1;
                        w_load_val = C_ACK_LOAD;
                    end
                end

                ST_UP_WAIT_ACK: begin
                    if (!i_act[r_stage] && w_timer_done) begin
                        w_state       = ST_FAULT;
                        w_enable      = '0;
                        w_seq_fault   = 1'b1;
                        w_fault_stage = r_stage;
                    end else if (i_sb_off_req) begin
                        w_state    = ST_DOWN_STEP;
                        w_floor_hi = 1'b0;
                        w_enable   = clear_highest(r_enable);
                        w_load     = 1'b1;
                    end else if (i_hv_off_req && w_hv_ramp) begin
                        w_state    = ST_DOWN_STEP;
                        w_floor_hi = 1'b1;
                        w_enable   = clear_highest(r_enable);
                        w_load     = 1'b1;
                    end else if (i_act[r_stage]) begin
                        w_state    = ST_UP_DWELL;
                        w_load     = 1'b1;
                        w_load_val = (r_stage == STG_CA) ? C_HEAT_LOAD : C_STEP_LOAD;
                    end
                end

                ST_UP_DWELL: begin
                    if (|w_act_lost) begin
                        w_state       = ST_FAULT;
                        w_enable      = '0;
                        w_seq_fault   = 1'b1;
                        w_fault_stage = lowest_set(w_act_lost);
                    end else if (i_sb_off_req) begin
                        w_state    = ST_DOWN_STEP;
                        w_floor_hi = 1'b0;
                        w_enable   = clear_highest(r_enable);
                        w_load     = 1'b1;
                    end else if (i_hv_off_req && w_hv_ramp) begin
                        w_state    = ST_DOWN_STEP;
                        w_floor_hi = 1'b1;
                        w_enable   = clear_highest(r_enable);
                        w_load     = 1'b1;
                    end else if (w_timer_done) begin
                        if (r_stage == STG_CA) begin
                            w_state = ST_SB_READY;
                        end else if (r_stage == STG_DRAMP) begin
                            w_state = ST_HV_READY;
                        end else begin
                            w_state    = ST_UP_WAIT_ACK;
                            w_stage    = w_next_stage;
                            w_enable   = r_enable | (6'b000001 << w_next_stage);
                            w_load     = 1'b1;
                            w_load_val = C_ACK_LOAD;
                        end
                    end
                end

                ST_SB_READY: begin
                    if (|w_act_lost) begin
                        w_state       = ST_FAULT;
                        w_enable      = '0;
                        w_seq_fault   = 1'b1;
                        w_fault_stage = lowest_set(w_act_lost);
                    end else if (i_sb_off_req) begin
                        w_state    = ST_DOWN_STEP;
                        w_floor_hi = 1'b0;
                        w_enable   = clear_highest(r_enable);
                        w_load     = 1'b1;
                    end else if (i_hv_on_req) begin
                        w_state    = ST_UP_WAIT_ACK;
                        w_stage    = STG_G1;
                        w_enable   = r_enable | 6'b000100;
                        w_load     = 1'b1;
                        w_load_val = C_ACK_LOAD;
                    end
                end

                ST_HV_READY: begin
                    if (|w_act_lost) begin
                        w_state       = ST_FAULT;
                        w_enable      = '0;
                        w_seq_fault   = 1'b1;
                        w_fault_stage = lowest_set(w_act_lost);
                    end else if (i_sb_off_req) begin
                        w_state    = ST_DOWN_STEP;
                        w_floor_hi = 1'b0;
                        w_enable   = clear_highest(r_enable);
                        w_load     = 1'b1;
                    end else if (i_hv_off_req) begin
                        w_state    = ST_DOWN_STEP;
                        w_floor_hi = 1'b1;
                        w_enable   = clear_highest(r_enable);
                        w_load     = 1'b1;
                    end
                end

                ST_DOWN_STEP: begin
                    // A standby-off during an HV-only ramp-down deepens the target.
                    if (i_sb_off_req) w_floor_hi = 1'b0;
                    w_below_floor = !(|r_enable) ||
                                    (w_floor_hi && (highest_set(r_enable) < STG_G1));
                    if (w_below_floor) begin
                        if (w_floor_hi) begin
                            w_state = ST_SB_READY;
                        end else begin
                            w_state = ST_OFF;
                            w_stage = STG_FAN;
                        end
                    end else if (w_timer_done) begin
                        w_enable = clear_highest(r_enable);
                        w_load   = 1'b1;
                    end
                end

                ST_FAULT: begin
                    w_enable = '0;
                    if (i_fault_clear && i_interlock_ok) begin
                        w_state       = ST_OFF;
                        w_stage       = STG_FAN;
                        w_seq_fault   = 1'b0;
                        w_fault_stage = 3'd0;
                    end
                end

                default: begin
                    w_state  = ST_FAULT;
                    w_enable = '0;
                end
            endcase
        end

        w_sb_ready = (w_state == ST_SB_READY) || (w_state == ST_HV_READY);
        w_hv_ready = (w_state == ST_HV_READY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_OFF;
            r_enable      <= '0;
            r_stage       <= STG_FAN;
            r_floor_hi    <= 1'b0;
            r_sb_ready    <= 1'b0;
            r_hv_ready    <= 1'b0;
            r_seq_fault   <= 1'b0;
            r_fault_stage <= 3'd0;
        end else begin
            r_state       <= w_state;
            r_enable      <= w_enable;
            r_stage       <= w_stage;
            r_floor_hi    <= w_floor_hi;
            r_sb_ready    <= w_sb_ready;
            r_hv_ready    <= w_hv_ready;
            r_seq_fault   <= w_seq_fault;
            r_fault_stage <= w_fault_stage;
        end
    end

    assign o_enable      = r_enable;
    assign o_sb_ready    = r_sb_ready;
    assign o_hv_ready    = r_hv_ready;
    assign o_seq_fault   = r_seq_fault;
    assign o_fault_stage = r_fault_stage;
    assign o_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hv_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hv_power_sequencer
// Description : Directed self-checking bench for hv_power_sequencer with
//               ACK_TIMEOUT=8, STEP_DELAY=4, CA_HEAT_DELAY=10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hv_power_sequencer;

    localparam logic [7:0] S_OFF   = 8'd0;
    localparam logic [7:0] S_WAIT  = 8'd1;
    localparam logic [7:0] S_DWELL = 8'd2;
    localparam logic [7:0] S_SB    = 8'd3;
    localparam logic [7:0] S_HV    = 8'd4;
    localparam logic [7:0] S_DOWN  = 8'd5;
    localparam logic [7:0] S_FAULT = 8'd6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sb_on_req = 1'b0, sb_off_req = 1'b0;
    logic       hv_on_req = 1'b0, hv_off_req = 1'b0;
    logic       interlock_ok = 1'b1, fault_clear = 1'b0;
    logic [5:0] act = 6'd0;
    logic [5:0] enable;
    logic       sb_ready, hv_ready, seq_fault;
    logic [2:0] fault_stage;
    logic [3:0] state;

    int n_vec  = 0;
    int n_miss = 0;

    hv_power_sequencer #(
        .ACK_TIMEOUT   (8),
        .STEP_DELAY    (4),
        .CA_HEAT_DELAY (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_sb_on_req    (sb_on_req),
        .i_sb_off_req   (sb_off_req),
        .i_hv_on_req    (hv_on_req),
        .i_hv_off_req   (hv_off_req),
        .i_interlock_ok (interlock_ok),
        .i_fault_clear  (fault_clear),
        .i_act          (act),
        .o_enable       (enable),
        .o_sb_ready     (sb_ready),
        .o_hv_ready     (hv_ready),
        .o_seq_fault    (seq_fault),
        .o_fault_stage  (fault_stage),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called right after the edge that enabled stage idx: ACT answers two
    // cycles after the enable, then the dwell must last exactly 'dwell' edges.
    task automatic ack_and_dwell(input int idx, input int dwell);
        tick();
        act[idx] = 1'b1;
        tick();
        chk("dwell_entry", {4'd0, state}, S_DWELL);
        tick(dwell - 1);
        chk("dwell_hold", {4'd0, state}, S_DWELL);
        tick();
    endtask

    task automatic ramp_to_hv();
        sb_on_req = 1'b1;
        tick();
        sb_on_req = 1'b0;
        chk("en_fan", {2'd0, enable}, 8'h01);
        ack_and_dwell(0, 4);
        chk("en_ca", {2'd0, enable}, 8'h03);
        ack_and_dwell(1, 10);
        chk("sb_state", {4'd0, state}, S_SB);
        chk("sb_ready", {7'd0, sb_ready}, 8'd1);
        chk("sb_hv_ready", {7'd0, hv_ready}, 8'd0);
        hv_on_req = 1'b1;
        tick();
        hv_on_req = 1'b0;
        chk("en_g1", {2'd0, enable}, 8'h07);
        ack_and_dwell(2, 4);
        chk("en_an", {2'd0, enable}, 8'h0F);
        ack_and_dwell(3, 4);
        chk("en_g2", {2'd0, enable}, 8'h1F);
        ack_and_dwell(4, 4);
        chk("en_dramp", {2'd0, enable}, 8'h3F);
        ack_and_dwell(5, 4);
        chk("hv_state", {4'd0, state}, S_HV);
        chk("hv_ready", {7'd0, hv_ready}, 8'd1);
        chk("hv_sb_ready", {7'd0, sb_ready}, 8'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_state", {4'd0, state}, S_OFF);
        chk("rst_enable", {2'd0, enable}, 8'h00);
        chk("rst_flags", {5'd0, sb_ready, hv_ready, seq_fault}, 8'd0);
        chk("rst_fstage", {5'd0, fault_stage}, 8'd0);
        reset = 1'b0;
        tick();

        // Interlock low in OFF blocks standby-on without latching a fault
        interlock_ok = 1'b0;
        sb_on_req = 1'b1;
        tick();
        chk("ilk_off_state", {4'd0, state}, S_OFF);
        chk("ilk_off_fault", {7'd0, seq_fault}, 8'd0);
        sb_on_req = 1'b0;
        interlock_ok = 1'b1;
        tick();

        // Full ramp
        ramp_to_hv();

        // Ordered HV shutdown back to standby
        hv_off_req = 1'b1;
        tick();
        hv_off_req = 1'b0;
        chk("down_entry_state", {4'd0, state}, S_DOWN);
        chk("down_entry_en", {2'd0, enable}, 8'h1F);
        chk("down_entry_rdy", {6'd0, sb_ready, hv_ready}, 8'd0);
        tick(3);
        chk("down_hold_g2", {2'd0, enable}, 8'h1F);
        tick();
        chk("down_g2", {2'd0, enable}, 8'h0F);
        tick(4);
        chk("down_an", {2'd0, enable}, 8'h07);
        tick(4);
        chk("down_g1", {2'd0, enable}, 8'h03);
        tick();
        chk("down_sb_state", {4'd0, state}, S_SB);
        chk("down_sb_ready", {7'd0, sb_ready}, 8'd1);

        // Standby off to OFF
        sb_off_req = 1'b1;
        tick();
        sb_off_req = 1'b0;
        chk("sboff_ca", {2'd0, enable}, 8'h01);
        chk("sboff_rdy", {7'd0, sb_ready}, 8'd0);
        tick(4);
        chk("sboff_fan", {2'd0, enable}, 8'h00);
        tick();
        chk("sboff_off", {4'd0, state}, S_OFF);
        act = 6'd0;
        tick();

        // Ack timeout on G1
        sb_on_req = 1'b1;
        tick();
        sb_on_req = 1'b0;
        ack_and_dwell(0, 4);
        ack_and_dwell(1, 10);
        hv_on_req = 1'b1;
        tick();
        hv_on_req = 1'b0;
        chk("to_en_g1", {2'd0, enable}, 8'h07);
        tick(7);
        chk("to_wait", {4'd0, state}, S_WAIT);
        tick();
        chk("to_fault", {4'd0, state}, S_FAULT);
        chk("to_enable", {2'd0, enable}, 8'h00);
        chk("to_seq_fault", {7'd0, seq_fault}, 8'd1);
        chk("to_stage", {5'd0, fault_stage}, 8'd2);
        chk("to_rdy", {6'd0, sb_ready, hv_ready}, 8'd0);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("to_clear_state", {4'd0, state}, S_OFF);
        chk("to_clear_fault", {5'd0, seq_fault, fault_stage[1:0]}, 8'd0);
        act = 6'd0;
        tick();

        // Interlock drop in HV_READY
        ramp_to_hv();
        interlock_ok = 1'b0;
        tick();
        chk("ilk_enable", {2'd0, enable}, 8'h00);
        chk("ilk_state", {4'd0, state}, S_FAULT);
        chk("ilk_stage", {5'd0, fault_stage}, 8'd7);
        fault_clear = 1'b1;
        tick();
        chk("ilk_clr_refused", {4'd0, state}, S_FAULT);
        chk("ilk_clr_fault", {7'd0, seq_fault}, 8'd1);
        interlock_ok = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("ilk_clr_ok", {4'd0, state}, S_OFF);
        act = 6'd0;
        tick();

        // sb_off coinciding with loss of AN acknowledge: fault wins
        ramp_to_hv();
        sb_off_req = 1'b1;
        act[3] = 1'b0;
        tick();
        sb_off_req = 1'b0;
        chk("sim_state", {4'd0, state}, S_FAULT);
        chk("sim_stage", {5'd0, fault_stage}, 8'd3);
        chk("sim_enable", {2'd0, enable}, 8'h00);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        act = 6'd0;
        tick();

        // Async reset mid-ramp
        sb_on_req = 1'b1;
        tick();
        sb_on_req = 1'b0;
        ack_and_dwell(0, 4);
        chk("ar_pre", {2'd0, enable}, 8'h03);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_enable", {2'd0, enable}, 8'h00);
        chk("ar_state", {4'd0, state}, S_OFF);
        #2;
        reset = 1'b0;
        act = 6'd0;
        tick();
        chk("ar_stays_off", {4'd0, state}, S_OFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
